// File: rtl/fft_bin_serializer_if.sv
// Valid/ready beat stream carrying one FFT bin (re, im, magnitude, index, last flag).
// The master drives the beat fields; the slave returns out_ready.
interface fft_bin_serializer_if #(
    parameter int DATA_W = 12,
    parameter int N_BINS = 8
) ();
    localparam int IDX_W = $clog2(N_BINS);

    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_re;
    logic [DATA_W-1:0]       out_im;
    logic [DATA_W:0]         out_mag;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;

    modport master (
        output out_valid, out_re, out_im, out_mag, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_re, out_im, out_mag, out_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_bin_serializer.sv
// Waits out the FFT pipeline after each start, snapshots the parallel bin buses,
// then streams the bins one per handshake together with an |re|+|im| estimate.
module fft_bin_serializer #(
    parameter int DATA_W        = 12,
    parameter int N_BINS        = 8,
    parameter int FFT_LATENCY   = 3,
    parameter int HALF_SPECTRUM = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_BINS*DATA_W-1:0] y_r_flat,
    input  logic [N_BINS*DATA_W-1:0] y_i_flat,
    fft_bin_serializer_if.master     m_out,
    output logic                     busy,
    output logic                     overrun
);
    localparam int IDX_W = $clog2(N_BINS);
    localparam int CNT_W = (FFT_LATENCY > 1) ? $clog2(FFT_LATENCY) : 1;
    localparam int LAST  = (HALF_SPECTRUM != 0) ? (N_BINS / 2) : (N_BINS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(FFT_LATENCY - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_overrun;
    logic [DATA_W-1:0] r_buf_re [N_BINS];
    logic [DATA_W-1:0] r_buf_im [N_BINS];

    logic              w_capture;
    logic              w_fire;
    logic              w_last;
    logic [DATA_W-1:0] w_re;
    logic [DATA_W-1:0] w_im;
    logic [DATA_W:0]   w_re_ext;
    logic [DATA_W:0]   w_im_ext;
    logic [DATA_W:0]   w_abs_re;
    logic [DATA_W:0]   w_abs_im;

    assign w_capture = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_fire    = (r_state == S_STREAM) && m_out.out_ready;
    assign w_last    = (r_idx == LAST_IDX);

    // Snapshot buffer: written only on the capture edge, so bus changes during STREAM are invisible.
    genvar gi;
    generate
        for (gi = 0; gi < N_BINS; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_buf_re[gi] <= '0;
                    r_buf_im[gi] <= '0;
                end else if (w_capture) begin
                    r_buf_re[gi] <= y_r_flat[gi*DATA_W +: DATA_W];
                    r_buf_im[gi] <= y_i_flat[gi*DATA_W +: DATA_W];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_START;
                    end
                end
                S_WAIT: begin
                    if (w_capture) begin
                        r_state <= S_STREAM;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_STREAM: begin
                    if (w_fire) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A start that lands while a frame is in flight (including its final handshake cycle) is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (start && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign w_re = r_buf_re[r_idx];
    assign w_im = r_buf_im[r_idx];

    // Absolute values are widened by one bit so the most negative input maps to +2^(DATA_W-1).
    assign w_re_ext = {w_re[DATA_W-1], w_re};
    assign w_im_ext = {w_im[DATA_W-1], w_im};
    assign w_abs_re = w_re[DATA_W-1] ? -w_re_ext : w_re_ext;
    assign w_abs_im = w_im[DATA_W-1] ? -w_im_ext : w_im_ext;

    assign m_out.out_valid = (r_state == S_STREAM);
    assign m_out.out_re    = w_re;
    assign m_out.out_im    = w_im;
    assign m_out.out_mag   = w_abs_re + w_abs_im;
    assign m_out.out_idx   = r_idx;
    assign m_out.out_last  = (r_state == S_STREAM) && w_last;

    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;
endmodule

// File: tb/tb_fft_bin_serializer.sv
// Directed bench for fft_bin_serializer: full and half spectrum frames, backpressure,
// overrun on start-while-busy, post-capture input changes and mid-frame reset.
module tb_fft_bin_serializer;
    localparam int DW = 12;
    localparam int NB = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             start2;
    logic [NB*DW-1:0] y_r;
    logic [NB*DW-1:0] y_i;
    logic             busy1, ovr1, busy2, ovr2;

    int tests_run = 0;
    int tests_failed = 0;

    int exp_re  [NB] = '{100, 1, 2, -2048, 4, 5, 6, 7};
    int exp_im  [NB] = '{-50, 0, 0, -2048, 0, 0, 0, 0};
    int exp_mag [NB] = '{150, 1, 2, 4096, 4, 5, 6, 7};

    fft_bin_serializer_if #(.DATA_W(DW), .N_BINS(NB)) s1 ();
    fft_bin_serializer_if #(.DATA_W(DW), .N_BINS(NB)) s2 ();

    fft_bin_serializer #(.DATA_W(DW), .N_BINS(NB), .FFT_LATENCY(3), .HALF_SPECTRUM(0)) dut_full (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .y_r_flat (y_r),
        .y_i_flat (y_i),
        .m_out    (s1.master),
        .busy     (busy1),
        .overrun  (ovr1)
    );

    fft_bin_serializer #(.DATA_W(DW), .N_BINS(NB), .FFT_LATENCY(3), .HALF_SPECTRUM(1)) dut_half (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .y_r_flat (y_r),
        .y_i_flat (y_i),
        .m_out    (s2.master),
        .busy     (busy2),
        .overrun  (ovr2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load_frame();
        for (int k = 0; k < NB; k++) begin
            y_r[k*DW +: DW] = exp_re[k][DW-1:0];
            y_i[k*DW +: DW] = exp_im[k][DW-1:0];
        end
    endtask

    // Called at a negedge; returns at the negedge after the capture edge E3.
    task automatic launch(input string name);
        load_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_e0"}, busy1, 1);
        check({name, "_valid_e0"}, s1.out_valid, 0);
        repeat (2) begin
            @(negedge clk);
            check({name, "_valid_wait"}, s1.out_valid, 0);
        end
        @(negedge clk);
    endtask

    // ready_mode 0: ready held high; 1: ready pattern 1,0,0 repeating.
    task automatic run_frame(input string name, input int ready_mode, input int start_at, input int rst_at);
        int  k = 0;
        int  pat = 0;
        int  budget = 0;
        bit  r;
        bit  hit_rst = 1'b0;
        while (k < NB && budget < 64 && !hit_rst) begin
            budget++;
            check({name, "_valid"}, s1.out_valid, 1);
            check({name, "_idx"}, s1.out_idx, k);
            check({name, "_re"}, s1.out_re, exp_re[k][DW-1:0]);
            check({name, "_im"}, s1.out_im, exp_im[k][DW-1:0]);
            check({name, "_mag"}, s1.out_mag, exp_mag[k]);
            check({name, "_last"}, s1.out_last, (k == NB - 1) ? 1 : 0);
            check({name, "_busy"}, busy1, 1);
            y_r = {$urandom, $urandom, $urandom};
            y_i = {$urandom, $urandom, $urandom};
            r = (ready_mode == 0) ? 1'b1 : ((pat % 3) == 0);
            pat++;
            s1.out_ready = r;
            start = (k == start_at);
            if (k == start_at) start_at = -1;
            rst = (k == rst_at);
            $display("[TB] %s beat idx=%0d re=%0d im=%0d mag=%0d last=%0b ready=%0b",
                     name, s1.out_idx, $signed(s1.out_re), $signed(s1.out_im),
                     s1.out_mag, s1.out_last, r);
            if (rst) hit_rst = 1'b1;
            else if (r && s1.out_valid) k++;
            @(negedge clk);
            start = 1'b0;
            rst = 1'b0;
        end
        s1.out_ready = 1'b1;
        if (hit_rst) begin
            check({name, "_rst_valid"}, s1.out_valid, 0);
            check({name, "_rst_busy"}, busy1, 0);
            check({name, "_rst_ovr"}, ovr1, 0);
            check({name, "_rst_last"}, s1.out_last, 0);
            check({name, "_rst_idx"}, s1.out_idx, 0);
            check({name, "_rst_re"}, s1.out_re, 0);
            check({name, "_rst_mag"}, s1.out_mag, 0);
        end else begin
            check({name, "_beats"}, k, NB);
            check({name, "_end_valid"}, s1.out_valid, 0);
            check({name, "_end_busy"}, busy1, 0);
            check({name, "_end_last"}, s1.out_last, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        y_r = '0;
        y_i = '0;
        s1.out_ready = 1'b1;
        s2.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", s1.out_valid, 0);
        check("rst_busy", busy1, 0);
        check("rst_ovr", ovr1, 0);
        check("rst_last", s1.out_last, 0);
        check("rst_idx", s1.out_idx, 0);
        check("rst_re", s1.out_re, 0);
        check("rst_im", s1.out_im, 0);
        check("rst_mag", s1.out_mag, 0);
        rst = 1'b0;
        @(negedge clk);

        launch("full");
        run_frame("full", 0, -1, -1);

        launch("bp");
        run_frame("bp", 1, -1, -1);

        launch("ovr");
        run_frame("ovr", 0, 2, -1);
        check("ovr_set", ovr1, 1);

        launch("after_ovr");
        run_frame("after_ovr", 0, -1, -1);
        check("ovr_sticky", ovr1, 1);

        launch("rst_mid");
        run_frame("rst_mid", 0, -1, 4);
        launch("post_rst");
        run_frame("post_rst", 0, -1, -1);
        check("post_rst_ovr", ovr1, 0);

        load_frame();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("half_busy_e0", busy2, 1);
        repeat (3) @(negedge clk);
        for (int k = 0; k <= NB / 2; k++) begin
            check("half_valid", s2.out_valid, 1);
            check("half_idx", s2.out_idx, k);
            check("half_re", s2.out_re, exp_re[k][DW-1:0]);
            check("half_mag", s2.out_mag, exp_mag[k]);
            check("half_last", s2.out_last, (k == NB / 2) ? 1 : 0);
            $display("[TB] half beat idx=%0d re=%0d mag=%0d last=%0b",
                     s2.out_idx, $signed(s2.out_re), s2.out_mag, s2.out_last);
            @(negedge clk);
        end
        check("half_end_valid", s2.out_valid, 0);
        check("half_end_busy", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
